// File: rtl/jk_pkg.sv
// Shared mode encoding for the JK bank and its users.
// Pure constants; no latency, no flow control.
package jk_pkg;

  localparam logic [1:0] JK_MODE_JK  = 2'd0;
  localparam logic [1:0] JK_MODE_D   = 2'd1;
  localparam logic [1:0] JK_MODE_T   = 2'd2;
  localparam logic [1:0] JK_MODE_CNT = 2'd3;

endpackage

// File: rtl/jk_bank_if.sv
// Control/data bundle for jk_bank; master drives controls, slave returns state and pulses.
// No backpressure: every enabled edge is accepted.
interface jk_bank_if #(
  parameter int WIDTH = 8
);

  logic             iCE;
  logic [1:0]       iMode;
  logic [WIDTH-1:0] iJ;
  logic [WIDTH-1:0] iK;
  logic [WIDTH-1:0] iD;
  logic             iUp;
  logic [WIDTH-1:0] oQ;
  logic [WIDTH-1:0] oRise;
  logic [WIDTH-1:0] oFall;
  logic             oTc;

  modport master (
    output iCE, iMode, iJ, iK, iD, iUp,
    input  oQ, oRise, oFall, oTc
  );

  modport slave (
    input  iCE, iMode, iJ, iK, iD, iUp,
    output oQ, oRise, oFall, oTc
  );

endinterface

// File: rtl/jk_cell.sv
// One JK storage bit with sync reset/set/enable; one-edge latency.
// oNext exposes the value the bit takes on the coming edge so the bank can register edge pulses.
module jk_cell #(
  parameter logic RST_BIT = 1'b0,
  parameter logic SET_BIT = 1'b1
) (
  input  logic iClk,
  input  logic iRst,
  input  logic iSet,
  input  logic iCE,
  input  logic iJ,
  input  logic iK,
  output logic oQ,
  output logic oNext
);

  logic r_q;
  logic w_jk_next;
  logic w_next;

  always_comb begin
    w_jk_next = r_q;
    case ({iJ, iK})
      2'b00:   w_jk_next = r_q;
      2'b01:   w_jk_next = 1'b0;
      2'b10:   w_jk_next = 1'b1;
      default: w_jk_next = ~r_q;
    endcase
  end

  always_comb begin
    w_next = r_q;
    if (iRst)
      w_next = RST_BIT;
    else if (iSet)
      w_next = SET_BIT;
    else if (iCE)
      w_next = w_jk_next;
  end

  always_ff @(posedge iClk) begin
    r_q <= w_next;
  end

  assign oQ    = r_q;
  assign oNext = w_next;

endmodule

// File: rtl/jk_bank.sv
// WIDTH-bit JK register with JK/D/T/counter modes, registered rise/fall and wrap pulses.
// One edge from inputs to oQ and pulses; no backpressure.
module jk_bank
  import jk_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RST_VALUE = '0,
  parameter logic [WIDTH-1:0] SET_VALUE = '1
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic       iSet,
  jk_bank_if.slave   bus
);

  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_je;
  logic [WIDTH-1:0] w_ke;
  logic [WIDTH-1:0] w_t;
  logic             w_wrap;
  logic [WIDTH-1:0] r_rise;
  logic [WIDTH-1:0] r_fall;
  logic             r_tc;

  // Ripple toggle chain: bit i flips when all lower bits are at the carry/borrow value.
  always_comb begin
    w_t[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++)
      w_t[i] = w_t[i-1] & (bus.iUp ? w_q[i-1] : ~w_q[i-1]);
  end

  always_comb begin
    w_je = bus.iJ;
    w_ke = bus.iK;
    case (bus.iMode)
      JK_MODE_JK: begin
        w_je = bus.iJ;
        w_ke = bus.iK;
      end
      JK_MODE_D: begin
        w_je = bus.iD;
        w_ke = ~bus.iD;
      end
      JK_MODE_T: begin
        w_je = bus.iJ;
        w_ke = bus.iJ;
      end
      default: begin
        w_je = w_t;
        w_ke = w_t;
      end
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_cell
      jk_cell #(
        .RST_BIT (RST_VALUE[gi]),
        .SET_BIT (SET_VALUE[gi])
      ) u_cell (
        .iClk  (iClk),
        .iRst  (iRst),
        .iSet  (iSet),
        .iCE   (bus.iCE),
        .iJ    (w_je[gi]),
        .iK    (w_ke[gi]),
        .oQ    (w_q[gi]),
        .oNext (w_next[gi])
      );
    end
  endgenerate

  assign w_wrap = bus.iUp ? (&w_q) : ~(|w_q);

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_rise <= '0;
      r_fall <= '0;
      r_tc   <= 1'b0;
    end else begin
      r_rise <= ~w_q & w_next;
      r_fall <= w_q & ~w_next;
      r_tc   <= ~iSet & bus.iCE & (bus.iMode == JK_MODE_CNT) & w_wrap;
    end
  end

  assign bus.oQ    = w_q;
  assign bus.oRise = r_rise;
  assign bus.oFall = r_fall;
  assign bus.oTc   = r_tc;

endmodule

// File: tb/tb_jk_bank.sv
// Directed-vector bench for jk_bank at WIDTH=4, expected values computed by hand.
module tb_jk_bank;
  import jk_pkg::*;

  localparam int W = 4;

  logic iClk = 1'b0;
  logic iRst;
  logic iSet;
  int   n_cmp = 0;
  int   n_bad = 0;

  jk_bank_if #(.WIDTH(W)) bus ();

  jk_bank #(
    .WIDTH     (W),
    .RST_VALUE (4'h0),
    .SET_VALUE (4'hF)
  ) dut (
    .iClk (iClk),
    .iRst (iRst),
    .iSet (iSet),
    .bus  (bus)
  );

  always #5 iClk = ~iClk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic set, input logic ce, input logic [1:0] mode,
                       input logic [W-1:0] j, input logic [W-1:0] k, input logic [W-1:0] d,
                       input logic up);
    iRst      = rst;
    iSet      = set;
    bus.iCE   = ce;
    bus.iMode = mode;
    bus.iJ    = j;
    bus.iK    = k;
    bus.iD    = d;
    bus.iUp   = up;
  endtask

  task automatic step();
    @(posedge iClk);
    #1;
  endtask

  task automatic expect_all(input string tag, input logic [W-1:0] q, input logic [W-1:0] r,
                            input logic [W-1:0] f, input logic tc);
    chk({tag, ".q"},    32'(bus.oQ),    32'(q));
    chk({tag, ".rise"}, 32'(bus.oRise), 32'(r));
    chk({tag, ".fall"}, 32'(bus.oFall), 32'(f));
    chk({tag, ".tc"},   32'(bus.oTc),   32'(tc));
  endtask

  initial begin
    drive(1, 1, 1, JK_MODE_JK, 4'hF, 4'hF, 4'h0, 1);
    step();
    expect_all("rst", 4'h0, 4'h0, 4'h0, 0);

    drive(0, 1, 1, JK_MODE_JK, 4'hF, 4'hF, 4'h0, 1);
    step();
    expect_all("set", 4'hF, 4'hF, 4'h0, 0);

    drive(0, 0, 1, JK_MODE_D, 4'h0, 4'h0, 4'h5, 1);
    step();
    expect_all("load5", 4'h5, 4'h0, 4'hA, 0);

    drive(0, 0, 1, JK_MODE_JK, 4'h3, 4'h6, 4'h0, 1);
    step();
    expect_all("jk", 4'h3, 4'h2, 4'h4, 0);

    drive(0, 0, 0, JK_MODE_JK, 4'h3, 4'h6, 4'h0, 1);
    step();
    expect_all("jk_hold", 4'h3, 4'h0, 4'h0, 0);

    drive(0, 0, 1, JK_MODE_D, 4'h0, 4'h0, 4'hA, 1);
    step();
    expect_all("d_a", 4'hA, 4'h8, 4'h1, 0);

    drive(0, 0, 1, JK_MODE_T, 4'hF, 4'h0, 4'h0, 1);
    step();
    expect_all("t1", 4'h5, 4'h5, 4'hA, 0);
    step();
    expect_all("t2", 4'hA, 4'hA, 4'h5, 0);

    drive(0, 0, 1, JK_MODE_D, 4'h0, 4'h0, 4'hE, 1);
    step();
    chk("load_e.q", 32'(bus.oQ), 32'hE);

    // Mode switch keeps oQ; count up across the wrap.
    drive(0, 0, 1, JK_MODE_CNT, 4'h0, 4'h0, 4'h0, 1);
    step();
    expect_all("up_f", 4'hF, 4'h1, 4'h0, 0);
    step();
    expect_all("up_0", 4'h0, 4'h0, 4'hF, 1);
    step();
    expect_all("up_1", 4'h1, 4'h1, 4'h0, 0);

    drive(0, 0, 1, JK_MODE_CNT, 4'h0, 4'h0, 4'h0, 0);
    step();
    expect_all("dn_0", 4'h0, 4'h0, 4'h1, 0);
    step();
    expect_all("dn_f", 4'hF, 4'hF, 4'h0, 1);

    drive(0, 0, 1, JK_MODE_D, 4'h0, 4'h0, 4'h3, 1);
    step();
    chk("load_3.q", 32'(bus.oQ), 32'h3);

    drive(0, 0, 1, JK_MODE_CNT, 4'h0, 4'h0, 4'h0, 1);
    step();
    expect_all("ce_4", 4'h4, 4'h4, 4'h3, 0);
    bus.iCE = 1'b0;
    step();
    expect_all("ce_hold", 4'h4, 4'h0, 4'h0, 0);
    bus.iCE = 1'b1;
    step();
    expect_all("ce_5", 4'h5, 4'h1, 4'h0, 0);

    drive(0, 0, 1, JK_MODE_D, 4'h0, 4'h0, 4'h7, 1);
    step();
    chk("load_7.q", 32'(bus.oQ), 32'h7);

    drive(1, 1, 1, JK_MODE_CNT, 4'h0, 4'h0, 4'h0, 1);
    step();
    expect_all("midrst", 4'h0, 4'h0, 4'h0, 0);

    drive(0, 0, 1, JK_MODE_CNT, 4'h0, 4'h0, 4'h0, 1);
    step();
    expect_all("restart", 4'h1, 4'h1, 4'h0, 0);

    // Set mid-count suppresses oTc even though the counter sits at all-ones.
    drive(0, 0, 1, JK_MODE_D, 4'h0, 4'h0, 4'hF, 1);
    step();
    drive(0, 1, 1, JK_MODE_CNT, 4'h0, 4'h0, 4'h0, 1);
    step();
    expect_all("set_cnt", 4'hF, 4'h0, 4'h0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/jk_bank.md
Name: jk_bank

Overview:
- Parametrised multi-bit successor to the single-bit JK flip-flop: WIDTH independent JK cells sharing one clock, reset, set and clock enable.
- Four run-time modes reuse the JK core: per-bit JK, parallel D load, per-bit toggle, and synchronous up/down counter.
- Provides registered per-bit rise/fall pulses and a counter terminal-count pulse.
- Used as a general status/flag register and small counter in control paths.

Parameters:
- WIDTH, 8, number of bits (1..32).
- RST_VALUE, {WIDTH{1'b0}}, oQ value after iRst.
- SET_VALUE, {WIDTH{1'b1}}, oQ value after iSet.

Ports:
- iClk  in  1  clock; all state changes on rising edge.
- iRst  in  1  synchronous reset, active-high; highest priority.
- iSet  in  1  synchronous set, active-high; below iRst.
- iCE  in  1  clock enable for mode operation; below iSet.
- iMode  in  2  0=JK, 1=D, 2=T, 3=CNT.
- iJ  in  WIDTH  J inputs (JK mode); toggle mask (T mode).
- iK  in  WIDTH  K inputs (JK mode only).
- iD  in  WIDTH  parallel load data (D mode).
- iUp  in  1  count direction in CNT: 1=up, 0=down.
- oQ  out  WIDTH  register state.
- oRise  out  WIDTH  per-bit 0->1 pulse, registered, aligned with new oQ.
- oFall  out  WIDTH  per-bit 1->0 pulse, registered, aligned with new oQ.
- oTc  out  1  counter wrap pulse, registered, aligned with wrapped oQ.

Behaviour:
- Reset: an edge with iRst=1 loads oQ=RST_VALUE and oRise=oFall=0, oTc=0, regardless of all other inputs.
- Set: iRst=0 and iSet=1 loads oQ=SET_VALUE; oTc=0; oRise/oFall reflect the actual bit changes.
- Hold: iRst=iSet=0 and iCE=0 keeps oQ; oRise=oFall=0 and oTc=0 (pulses last exactly one cycle).
- Active (iCE=1): each bit's next value follows JK semantics on effective (Je,Ke): 00 hold, 01 clear, 10 set, 11 toggle.
- Effective inputs per mode:
  - JK: Je=iJ[i], Ke=iK[i].
  - D: Je=iD[i], Ke=~iD[i].
  - T: Je=Ke=iJ[i]; iK is ignored.
  - CNT: Je=Ke=t[i], where t[0]=1. Up: t[i]=&oQ[i-1:0]. Down: t[i]=&~oQ[i-1:0].
- Latency: one edge from inputs to oQ. oRise=~Qold&Qnew and oFall=Qold&~Qnew are computed on the same edge as oQ.
- oTc: set to 1 on the edge where CNT with iCE=1 wraps (up from all-ones to 0, down from 0 to all-ones); 0 on every other edge.
- Mode or iUp change takes effect on the next edge with no pipeline state. A mode switch mid-count keeps oQ.
- WIDTH=1: CNT toggles every enabled cycle; oTc=1 on each up 1->0 and each down 0->1.
- Reset mid-count: the count is lost, and the counter restarts from RST_VALUE on the next enabled edge.

Decomposition:
- Package jk_pkg: mode constants JK_MODE_JK=2'd0, JK_MODE_D=2'd1, JK_MODE_T=2'd2, JK_MODE_CNT=2'd3.
- Sub-module jk_cell, instantiated WIDTH times:
  - One bit of state, with parameters RST_BIT and SET_BIT.
  - Inputs iClk, iRst, iSet, iCE, iJ, iK; output oQ.
  - Contains the JK next-state logic and the register.
- Top level jk_bank: effective-J/K mux, counter toggle chain, edge pulses and oTc.

Test Plan:
- WIDTH=4, RST_VALUE=0, SET_VALUE=4'hF. Assert iRst with iSet=1, iCE=1 -> oQ=0, oRise=0, oFall=0, oTc=0. Release iRst with iSet=1 -> oQ=F, oRise=F.
- JK mode, oQ=4'b0101, iCE=1, iJ=4'b0011, iK=4'b0110 -> next oQ=4'b0011; oRise=4'b0010, oFall=4'b0100. Repeat the same edge with iCE=0 -> oQ held at 4'b0011, oRise=oFall=0.
- D mode, iD=4'hA -> oQ=A. Then T mode, iJ=4'hF, iK=4'h0 -> oQ=5; a second edge gives oQ=A.
- CNT up from oQ=E, 3 enabled edges -> oQ=F,0,1; oTc=1 only with oQ=0. CNT down from 1, 2 edges -> oQ=0,F; oTc=1 only with F.
- CNT up with iCE toggling 1,0,1 from oQ=3 -> oQ=4,4,5; oRise/oFall=0 in the held cycle.
- CNT up at oQ=7, iRst=1 and iSet=1 together -> oQ=0, oTc=0. Next enabled edge -> oQ=1.
